// File: rtl/bist_sequencer.sv
// bist_sequencer: control FSM for the circular-BIST wrapper around the 4-requester arbiter.
//
// One self-test runs per accepted rising edge of bist_start:
//   INIT    - pulse cut_reset (also clears the MISR) and lfsr_load for one cycle
//   RUN     - assert misr_en for exactly TEST_CYCLES cycles
//   COMPARE - sample signature_in against GOLDEN_SIG
//   DONE    - hold bist_end and pass_fail until the next accepted start or reset
// The edge that samples the start is E0, and bist_end rises at edge E(TEST_CYCLES+2).
//
// Ports:
//   clock        in   system clock, rising-edge
//   reset        in   synchronous, active-high reset; aborts any test in progress
//   bist_start   in   test request; only a 0->1 transition starts a test
//   signature_in in   current MISR contents [MISR_BITS-1:0]
//   test_mode    out  high from INIT through COMPARE; muxes the LFSR onto the CUT inputs
//   cut_reset    out  one-cycle reset pulse to the CUT and MISR clear
//   lfsr_load    out  one-cycle LFSR seed load
//   misr_en      out  MISR compaction enable
//   bist_end     out  test complete
//   pass_fail    out  1 = signature matched; valid only while bist_end=1
//
// Optional feature, enabled by defining BIST_STICKY_FAIL_EN: once any run mismatches,
// pass_fail stays 0 for every later run until reset.

module bist_sequencer #(
    parameter int unsigned          MISR_BITS   = 8,
    parameter int unsigned          TEST_CYCLES = 255,
    parameter logic [MISR_BITS-1:0] GOLDEN_SIG  = {MISR_BITS{1'b0}},
    parameter int unsigned          CNT_W       = $clog2(TEST_CYCLES + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bist_start,
    input  logic [MISR_BITS-1:0] signature_in,
    output logic                 test_mode,
    output logic                 cut_reset,
    output logic                 lfsr_load,
    output logic                 misr_en,
    output logic                 bist_end,
    output logic                 pass_fail
);

    typedef enum logic [2:0] {StIdle, StInit, StRun, StCompare, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TEST_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             start_rise;
    logic             pass_q, pass_d;
    logic             fail_seen_q, fail_seen_d;
    logic             result;

    // Output flops, loaded with the Moore decode of the next state so they stay glitch-free
    // while keeping the same cycle timing as a decode of the current state.
    logic test_mode_q, cut_reset_q, lfsr_load_q, misr_en_q, bist_end_q, pass_fail_q;
    logic test_mode_d, cut_reset_d, lfsr_load_d, misr_en_d, bist_end_d, pass_fail_d;

    assign start_rise = bist_start & ~start_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        fail_seen_d = fail_seen_q;
        unique case (state_q)
            StIdle: begin
                if (start_rise) state_d = StInit;
            end
            StInit: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                // Holding at CntLast rather than incrementing keeps the counter from wrapping.
                if (cnt_q == CntLast) begin
                    state_d = StCompare;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCompare: begin
                pass_d = (signature_in == GOLDEN_SIG);
                if (signature_in != GOLDEN_SIG) fail_seen_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (start_rise) state_d = StInit;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef BIST_STICKY_FAIL_EN
    assign result = pass_d & ~fail_seen_d;
`else
    assign result = pass_d;
`endif

    always_comb begin
        test_mode_d = (state_d == StInit) || (state_d == StRun) || (state_d == StCompare);
        cut_reset_d = (state_d == StInit);
        lfsr_load_d = (state_d == StInit);
        misr_en_d   = (state_d == StRun);
        bist_end_d  = (state_d == StDone);
        pass_fail_d = (state_d == StDone) && result;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            test_mode_q <= 1'b0;
            cut_reset_q <= 1'b0;
            lfsr_load_q <= 1'b0;
            misr_en_q   <= 1'b0;
            bist_end_q  <= 1'b0;
            pass_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= bist_start;
            pass_q      <= pass_d;
            fail_seen_q <= fail_seen_d;
            test_mode_q <= test_mode_d;
            cut_reset_q <= cut_reset_d;
            lfsr_load_q <= lfsr_load_d;
            misr_en_q   <= misr_en_d;
            bist_end_q  <= bist_end_d;
            pass_fail_q <= pass_fail_d;
        end
    end

    assign test_mode = test_mode_q;
    assign cut_reset = cut_reset_q;
    assign lfsr_load = lfsr_load_q;
    assign misr_en   = misr_en_q;
    assign bist_end  = bist_end_q;
    assign pass_fail = pass_fail_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Testbench for bist_sequencer. A timeline model (cycles elapsed since the accepted start)
// pushes the expected output vector every cycle and the expected verdict at each test end;
// a separate monitor pops and compares on the falling edge.

module tb_bist_sequencer;

    localparam int unsigned MB   = 8;
    localparam int unsigned TC   = 4;
    localparam logic [7:0]  GOLD = 8'hA5;

    logic       clock = 1'b0;
    logic       reset;
    logic       bist_start;
    logic [7:0] signature_in;
    logic       test_mode, cut_reset, lfsr_load, misr_en, bist_end, pass_fail;

    bist_sequencer #(
        .MISR_BITS  (MB),
        .TEST_CYCLES(TC),
        .GOLDEN_SIG (GOLD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bist_start  (bist_start),
        .signature_in(signature_in),
        .test_mode   (test_mode),
        .cut_reset   (cut_reset),
        .lfsr_load   (lfsr_load),
        .misr_en     (misr_en),
        .bist_end    (bist_end),
        .pass_fail   (pass_fail)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic tm;
        logic cr;
        logic ll;
        logic me;
        logic be;
        logic pf;
    } outv_t;

    outv_t exp_q[$];
    bit    res_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    // Reference model: a test is "busy" for TC+2 cycles after the accepting edge.
    // since==0 is the reset/seed cycle, 1..TC are compaction cycles, TC+1 is the compare cycle.
    bit m_busy, m_done, m_prev_start, m_last_pf, m_fail_seen;
    int m_since;

    always @(posedge clock) begin
        outv_t e;
        bit    ok;
        if (reset) begin
            m_busy       = 0;
            m_done       = 0;
            m_since      = 0;
            m_prev_start = 0;
            m_last_pf    = 0;
            m_fail_seen  = 0;
        end else begin
            if (m_busy) begin
                m_since++;
                if (m_since == TC + 2) begin
                    ok = (signature_in == GOLD);
`ifdef BIST_STICKY_FAIL_EN
                    m_last_pf = ok && !m_fail_seen && ok;
                    if (!ok) m_fail_seen = 1;
`else
                    m_last_pf = ok;
`endif
                    res_q.push_back(m_last_pf);
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (bist_start && !m_prev_start) begin
                m_busy  = 1;
                m_since = 0;
                m_done  = 0;
            end
            m_prev_start = bist_start;
        end
        e.tm = m_busy;
        e.cr = m_busy && (m_since == 0);
        e.ll = m_busy && (m_since == 0);
        e.me = m_busy && (m_since >= 1) && (m_since <= TC);
        e.be = m_done;
        e.pf = m_done && m_last_pf;
        exp_q.push_back(e);
    end

    // Monitor.
    logic end_prev = 1'b0;

    always @(negedge clock) begin
        outv_t e;
        outv_t act;
        bit    r;
        act = '{tm: test_mode, cr: cut_reset, ll: lfsr_load, me: misr_en, be: bist_end,
                pf: pass_fail};
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got tm,cr,ll,me,be,pf=%b required %b",
                         $time, act, e);
            end
        end
        if (bist_end === 1'b1 && end_prev !== 1'b1) begin
            n_vec++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL verdict t=%0t: got bist_end rise required none pending", $time);
            end else begin
                r = res_q.pop_front();
                if (pass_fail !== r) begin
                    n_fail++;
                    $display("FAIL verdict t=%0t: got pass_fail=%b required %b",
                             $time, pass_fail, r);
                end
            end
        end
        end_prev = bist_end;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic run(input logic [7:0] sig, input int hold);
        signature_in = sig;
        bist_start   = 1'b1;
        cyc(hold);
        bist_start = 1'b0;
        cyc(TC + 6);
    endtask

    initial begin
        reset        = 1'b1;
        bist_start   = 1'b0;
        signature_in = 8'h00;
        cyc(2);
        reset = 1'b0;
        cyc(20);

        run(8'hA5, 1);
        run(8'hA4, 1);

        // Held start: one run only, then a re-raise starts a second one.
        signature_in = GOLD;
        bist_start   = 1'b1;
        cyc(30);
        bist_start = 1'b0;
        cyc(2);
        run(GOLD, 1);

        // Reset during the third compaction cycle.
        bist_start = 1'b1;
        cyc(1);
        bist_start = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        run(GOLD, 1);

        // Fail then pass, then reset and pass.
        run(8'h00, 1);
        run(GOLD, 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        run(GOLD, 1);

        // Start already high across a reset release.
        reset      = 1'b1;
        bist_start = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(TC + 6);
        bist_start = 1'b0;
        cyc(2);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) bist_start = ~bist_start;
            signature_in = ($urandom_range(0, 1) == 1) ? GOLD : 8'($urandom);
            reset        = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        reset      = 1'b0;
        bist_start = 1'b0;
        cyc(TC + 8);

        n_vec++;
        if (res_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending: got %0d unreported verdicts required 0", res_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Control FSM for the circular-BIST wrapper around the 4-requester arbiter.
- On a `bist_start` rising edge it runs one fixed-length self-test:
  - resets the CUT and loads the LFSR seed;
  - drives the pattern/MISR enables for a programmed number of cycles;
  - compares the final MISR signature against a golden value.
- Reports the result on `bist_end` / `pass_fail`. Sits in `top` between the external BIST pins and the LFSR/MISR/CUT datapath.

Parameters:
- MISR_BITS, 8, signature width (8 or 16).
- TEST_CYCLES, 255, number of RUN cycles with MISR compaction enabled; must be ≥1.
- GOLDEN_SIG, {MISR_BITS{1'b0}}, expected fault-free signature.
- CNT_W, $clog2(TEST_CYCLES+1), cycle-counter width (derived, do not override).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- bist_start  in  1  test request; only a 0→1 transition is acted on.
- signature_in  in  MISR_BITS  current MISR contents.
- test_mode  out  1  high IDLE-exit through COMPARE; muxes LFSR onto CUT inputs.
- cut_reset  out  1  one-cycle reset pulse to the CUT and MISR clear.
- lfsr_load  out  1  one-cycle LFSR seed load.
- misr_en  out  1  MISR compaction enable.
- bist_end  out  1  test complete; held until next accepted start or reset.
- pass_fail  out  1  1 = signature matched; valid only while `bist_end`=1.

Behaviour:
- Reset: synchronous, active-high. State=IDLE, counter=0, start_q=0. All outputs 0.
- Reset wins over every other event. Asserting it in any state, including mid-RUN, aborts the test: IDLE next edge, `bist_end`=0, `pass_fail`=0.
- start_q registers `bist_start` every cycle. start_rise = bist_start & ~start_q.
- States: IDLE, INIT, RUN, COMPARE, DONE. All outputs are registered Moore decodes.
- IDLE: all outputs 0. start_rise → INIT.
- INIT (1 cycle):
  - `test_mode`=1, `cut_reset`=1, `lfsr_load`=1, counter cleared.
  - → RUN.
- RUN:
  - `test_mode`=1, `misr_en`=1, counter increments each cycle.
  - When counter==TEST_CYCLES-1 → COMPARE, so RUN lasts exactly TEST_CYCLES cycles.
- COMPARE (1 cycle):
  - `test_mode`=1, `misr_en`=0.
  - Registers pass = (signature_in == GOLDEN_SIG). Full-width equality, no masking.
  - → DONE.
- DONE:
  - `bist_end`=1, `pass_fail`=registered pass, `test_mode`=0.
  - start_rise → INIT and `bist_end` drops the same edge.
- Latency: the edge sampling start_rise is E0. `bist_end` goes high at edge E(TEST_CYCLES+2).
- start_rise in INIT/RUN/COMPARE is ignored. No queueing, no restart.
- `bist_start` held high: exactly one run. A new run requires a 0 then 1 on `bist_start`.
- `bist_start` already high when reset deasserts: start_q=0, so it counts as a rising edge on the first post-reset cycle.
- Counter saturates logically at TEST_CYCLES-1. No wrap is reachable.
- TEST_CYCLES=1: RUN lasts a single cycle.

Optional Feature:
- Macro: BIST_STICKY_FAIL_EN.
- Defined:
  - A fail_seen flag sets on any COMPARE mismatch and clears only on reset.
  - In DONE, `pass_fail` = pass & ~fail_seen.
  - A later passing run still reports 0.
- Undefined: `pass_fail` reflects only the most recent run.

Test Plan:
All cases use MISR_BITS=8, TEST_CYCLES=4, GOLDEN_SIG=8'hA5.
- Reset asserted 2 cycles, `bist_start` 0 → every output 0, `bist_end` stays 0 for 20 cycles.
- Pulse `bist_start` for 1 cycle, `signature_in`=8'hA5 throughout:
  - `cut_reset`/`lfsr_load` high for exactly 1 cycle, `misr_en` high for exactly 4 cycles;
  - `bist_end`=1 at E6 with `pass_fail`=1.
- Same run with `signature_in`=8'hA4 at COMPARE → `bist_end`=1, `pass_fail`=0.
- Hold `bist_start` high for 30 cycles → exactly one run, `bist_end` stays 1 with no re-entry to INIT. Drop, then re-raise → second run begins and `bist_end` falls on the accepting edge.
- Assert reset during the 3rd RUN cycle → IDLE next edge, `misr_en`=0, `bist_end`=0. A fresh start completes normally.
- Fail run (8'h00) then pass run (8'hA5) → `pass_fail`=1 on the second run without BIST_STICKY_FAIL_EN, 0 with it. Reset then a pass run → 1 in both builds.
